// File: rtl/mdu_defs_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : mdu_defs_pkg                                                 |
// | Description : Shared Op/state encodings and default latencies for the      |
// |               multiply/divide unit and the control-unit decoder.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package mdu_defs_pkg;

  // Op encodings, also used by the control-unit decoder
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_NOP6  = 3'd6,
    MDU_NOP7  = 3'd7
  } mdu_op_e;

  // Sequencer state encodings
  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Default busy latencies
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // True for the ops that occupy the unit for several cycles
  function automatic logic mdu_is_multicycle(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// +----------------------------------------------------------------------------+
// | Module      : mdu_arith                                                    |
// | Description : Combinational 32x32 multiply / divide datapath. Produces the |
// |               64-bit {hi,lo} result and a divide-by-zero flag.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mdu_arith
  import mdu_defs_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div0_o
);

  logic               w_b_zero;
  logic [31:0]        w_b_safe;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quot_u;
  logic [31:0]        w_rem_u;

  // A zero divisor is replaced by 1 so the dividers never see 0; the result is discarded anyway
  assign w_b_zero = (b_i == 32'd0);
  assign w_b_safe = w_b_zero ? 32'd1 : b_i;

  // Sign-extended / zero-extended full-width products
  assign w_prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign w_prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed division truncates toward zero; remainder takes the dividend's sign
  assign w_quot_s = $signed(a_i) / $signed(w_b_safe);
  assign w_rem_s  = $signed(a_i) % $signed(w_b_safe);
  assign w_quot_u = a_i / w_b_safe;
  assign w_rem_u  = a_i % w_b_safe;

  // Select the result for the requested op; remainder goes to HI, quotient to LO
  always_comb begin
    res_o  = 64'd0;
    div0_o = 1'b0;
    case (mdu_op_e'(op_i))
      MDU_MULT:  res_o = w_prod_s;
      MDU_MULTU: res_o = w_prod_u;
      MDU_DIV: begin
        res_o  = {w_rem_s, w_quot_s};
        div0_o = w_b_zero;
      end
      MDU_DIVU: begin
        res_o  = {w_rem_u, w_quot_u};
        div0_o = w_b_zero;
      end
      default: res_o = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : mult_div_unit                                                |
// | Description : Multi-cycle multiply/divide unit with HI/LO registers for    |
// |               the E stage. Busy is a registered state output; HI/LO are    |
// |               updated only at a commit edge or an MTHI/MTLO edge.          |
// |               Optional feature macro: MDU_CANCEL_EN (honours Cancel).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mult_div_unit
  import mdu_defs_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
)(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      tmp_hi_q, tmp_hi_d;
  logic [31:0]      tmp_lo_q, tmp_lo_d;
  logic             tmp_wr_q, tmp_wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      w_res;
  logic             w_div0;
  logic             w_cancel;

`ifdef MDU_CANCEL_EN
  assign w_cancel = Cancel;
`else
  // Cancel is tied off in this build; the port is kept for a uniform interface
  logic unused_cancel;
  assign unused_cancel = Cancel;
  assign w_cancel      = 1'b0;
`endif

  mdu_arith u_arith (
    .op_i   (Op),
    .a_i    (A),
    .b_i    (B),
    .res_o  (w_res),
    .div0_o (w_div0)
  );

  // Next-state logic: launch/stage in IDLE, count down and commit (or flush) in BUSY
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    tmp_wr_d = tmp_wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MDU_IDLE: begin
        if (Start && !w_cancel) begin
          case (mdu_op_e'(Op))
            MDU_MULT, MDU_MULTU: begin
              state_d  = MDU_BUSY;
              busy_d   = 1'b1;
              cnt_d    = C_MULT_LOAD;
              tmp_hi_d = w_res[63:32];
              tmp_lo_d = w_res[31:0];
              tmp_wr_d = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
              // Division by zero still occupies the unit but never commits
              state_d  = MDU_BUSY;
              busy_d   = 1'b1;
              cnt_d    = C_DIV_LOAD;
              tmp_hi_d = w_res[63:32];
              tmp_lo_d = w_res[31:0];
              tmp_wr_d = !w_div0;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default:  ;
          endcase
        end
      end
      MDU_BUSY: begin
        // Start is ignored here; cancel wins over a same-cycle commit
        if (w_cancel) begin
          state_d  = MDU_IDLE;
          busy_d   = 1'b0;
          cnt_d    = '0;
          tmp_wr_d = 1'b0;
        end else if (cnt_q == C_CNT_ONE) begin
          if (tmp_wr_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
          state_d  = MDU_IDLE;
          busy_d   = 1'b0;
          cnt_d    = '0;
          tmp_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, staging and architectural registers; reset aborts any op in flight
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      tmp_wr_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      tmp_wr_q <= tmp_wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_mult_div_unit                                             |
// | Description : Self-checking bench for mult_div_unit: directed scenarios    |
// |               plus randomized ops against an arithmetic reference model.   |
// |               Expectations for Cancel follow MDU_CANCEL_EN.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cancel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests = 0;
  int fails = 0;

  // Reference architectural state
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .Cancel (Cancel),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int latency(input logic [2:0] op);
    if (op <= 3'd1) return MULT_N;
    if (op <= 3'd3) return DIV_N;
    return 0;
  endfunction

  // Architectural effect of one op, from plain 64-bit arithmetic
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        p = q; m_lo = p[31:0];
        p = r; m_hi = p[31:0];
      end
      3'd3: if (b != 0) begin
        p = ua / ub; m_lo = p[31:0];
        p = ua % ub; m_hi = p[31:0];
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op and check Busy / HI / LO on every cycle until it is visible
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int          n;
    logic [31:0] ph, pl;
    n  = latency(op);
    ph = m_hi;
    pl = m_lo;
    Start = 1'b1; Op = op; A = a; B = b;
    step();
    Start = 1'b0; A = $urandom; B = $urandom;
    model_apply(op, a, b);
    for (int i = 0; i < n; i++) begin
      check({tag, "/busy"},    32'(Busy), 32'd1);
      check({tag, "/hi_hold"}, HI, ph);
      check({tag, "/lo_hold"}, LO, pl);
      step();
    end
    check({tag, "/idle"}, 32'(Busy), 32'd0);
    check({tag, "/hi"},   HI, m_hi);
    check({tag, "/lo"},   LO, m_lo);
  endtask

  initial begin
    int          busy_cycles;
    logic [31:0] ph, pl;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    Reset = 1'b1; Start = 1'b0; Cancel = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
    step(); step();
    check("reset/busy", 32'(Busy), 32'd0);
    check("reset/hi",   HI, 32'd0);
    check("reset/lo",   LO, 32'd0);
    Reset = 1'b0;
    step();

    // 1: signed multiply
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult");
    check("mult/hi_const", HI, 32'hFFFF_FFFF);
    check("mult/lo_const", LO, 32'hFFFF_FFFA);

    // 2: unsigned multiply
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
    check("multu/hi_const", HI, 32'hFFFF_FFFE);
    check("multu/lo_const", LO, 32'h0000_0001);

    // 3: signed divide, then divide by zero
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div");
    check("div/lo_const", LO, 32'hFFFF_FFFD);
    check("div/hi_const", HI, 32'hFFFF_FFFF);
    run_op(3'd2, 32'd12345, 32'd0, "div0");
    check("div0/lo_const", LO, 32'hFFFF_FFFD);
    check("div0/hi_const", HI, 32'hFFFF_FFFF);

    // 4: MTLO, then a Start injected while busy
    run_op(3'd5, 32'h1234_5678, 32'd0, "mtlo");
    check("mtlo/lo_const", LO, 32'h1234_5678);
    Start = 1'b1; Op = 3'd0; A = 32'h8000_0000; B = 32'd3;
    step();
    Start = 1'b0;
    model_apply(3'd0, 32'h8000_0000, 32'd3);
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!Busy) break;
      busy_cycles++;
      if (i == 1) begin
        $display("[TB] note: protocol violation injected (Start while Busy)");
        Start = 1'b1; Op = 3'd4; A = 32'hDEAD_BEEF;
      end else begin
        Start = 1'b0;
      end
      step();
    end
    Start = 1'b0;
    check("inject/busy_cycles", 32'(busy_cycles), 32'(MULT_N));
    check("inject/hi", HI, 32'hFFFF_FFFE);
    check("inject/lo", LO, 32'h8000_0000);

    // 5: asynchronous reset mid-divide
    Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd7;
    step();
    Start = 1'b0;
    step(); step();
    #2 Reset = 1'b1;
    #1;
    check("areset/busy", 32'(Busy), 32'd0);
    check("areset/hi",   HI, 32'd0);
    check("areset/lo",   LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    step();
    Reset = 1'b0;
    step();
    run_op(3'd0, 32'h0000_1234, 32'h0000_0010, "post_reset_mult");

    // 6: Cancel on the 4th busy cycle of a DIVU
    run_op(3'd4, 32'hAAAA_5555, 32'd0, "pre_mthi");
    run_op(3'd5, 32'h5555_AAAA, 32'd0, "pre_mtlo");
    ph = m_hi; pl = m_lo;
    Start = 1'b1; Op = 3'd3; A = 32'd1000; B = 32'd7;
    step();
    Start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("cancel/busy_pre", 32'(Busy), 32'd1);
      step();
    end
    check("cancel/busy_4th", 32'(Busy), 32'd1);
    Cancel = 1'b1;
    step();
    Cancel = 1'b0;
`ifdef MDU_CANCEL_EN
    check("cancel/busy_after", 32'(Busy), 32'd0);
    step(); step(); step(); step(); step(); step(); step();
    check("cancel/busy_late", 32'(Busy), 32'd0);
    check("cancel/hi", HI, ph);
    check("cancel/lo", LO, pl);
`else
    model_apply(3'd3, 32'd1000, 32'd7);
    for (int i = 5; i <= DIV_N; i++) begin
      check("nocancel/busy", 32'(Busy), 32'd1);
      check("nocancel/hi_hold", HI, ph);
      step();
    end
    check("nocancel/idle", 32'(Busy), 32'd0);
    check("nocancel/hi", HI, 32'd6);
    check("nocancel/lo", LO, 32'd142);
`endif

    // Cancel together with an MTHI Start in IDLE
    Start = 1'b1; Cancel = 1'b1; Op = 3'd4; A = 32'hCAFE_F00D;
    step();
    Start = 1'b0; Cancel = 1'b0;
`ifndef MDU_CANCEL_EN
    model_apply(3'd4, 32'hCAFE_F00D, 32'd0);
`endif
    check("cancel_mthi/hi",   HI, m_hi);
    check("cancel_mthi/busy", 32'(Busy), 32'd0);

    // Randomized ops, including no-ops and zero divisors
    for (int k = 0; k < 30; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 17));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", k, rop));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
